sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Producer side of the 3x3 pixel-matrix interface that sobel_core consumes.
- Accepts a raster-order grayscale pixel stream, one pixel per valid cycle, and keeps two line buffers plus a 3x3 shift window.
- Emits a registered 3x3 window with a valid strobe whenever a full window lies inside the frame.
- Sits between the grayscale converter and sobel_core; a wrapper casts matrix_o to sobel_matrix.

Parameters:
- PIXEL_WIDTH_IN, 8, bits per input pixel.
- IMG_WIDTH, 64, pixels per line (>=3).
- IMG_HEIGHT, 64, lines per frame (>=3).

Ports:
- clk_i  input  1  single clock, all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- px_i  input  PIXEL_WIDTH_IN  input pixel.
- px_valid_i  input  1  px_i is accepted this cycle. No backpressure.
- frame_start_i  input  1  qualified by px_valid_i: this pixel is row 0, col 0.
- matrix_o  output  9*PIXEL_WIDTH_IN  window, flat. Slot k=3*v+p occupies bits [PIXEL_WIDTH_IN*k +: PIXEL_WIDTH_IN] and holds vector<v>.pix<p>.
- matrix_valid_o  output  1  matrix_o holds a complete in-frame window.
- frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync release): matrix_o=0, matrix_valid_o=0, frame_done_o=0, col=0, row=0. Line buffer contents are not reset and are don't-care until overwritten.
- Counters: col is 0..IMG_WIDTH-1, row is 0..IMG_HEIGHT-1, both $clog2-sized. They advance only on accepted pixels. col wraps to 0 and row increments. After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- frame_start_i && px_valid_i: the pixel is processed as col=0, row=0 regardless of counter state. Afterwards col=1, row=0. This resynchronises mid-frame. frame_start_i without px_valid_i is ignored.
- Line buffers: lb0 holds the previous line, lb1 the line before it, each IMG_WIDTH deep, indexed by col. On an accepted pixel: read lb0[col] and lb1[col], then write lb1[col]<=lb0[col] and lb0[col]<=px_i.
- Window update on an accepted pixel, for each v: w[v][0]<=w[v][1], w[v][1]<=w[v][2]. New column: w[0][2]<=lb1[col] (row-2), w[1][2]<=lb0[col] (row-1), w[2][2]<=px_i (current).
- Orientation: vector0 is the top row, vector2 the bottom row; pix0 is the leftmost column, pix2 the newest column. This matches the sign convention of sobel_core (x: pix2-pix0, y: vector2-vector0).
- matrix_o is the window register itself. It changes only on accepted pixels and holds between them.
- matrix_valid_o is registered.
  - It is 1 in the cycle after accepting the pixel at (col,row) when col>=2 && row>=2, evaluated on the pre-increment counters with frame_start override applied. Otherwise 0.
  - It is 0 in any cycle following px_valid_i=0.
  - Latency is 1 clk from the accepting edge. The window's bottom-right pixel is the accepted pixel.
- Windows straddling a line boundary (col 0,1) hold stale columns from the previous line and are never flagged valid.
- frame_done_o is 1 in the cycle after accepting the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1), otherwise 0. It coincides with the last matrix_valid_o of the frame.
- Valid windows per full frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Reset mid-frame: outputs clear immediately and counters return to 0. The next accepted pixel is row 0, col 0, and no valid is emitted before row 2, col 2.

Test Plan:
- Bench overrides IMG_WIDTH=8, IMG_HEIGHT=4; every cycle feed px=row*16+col with frame_start on first pixel -> first matrix_valid_o one cycle after pixel (2,2). Window is vector0={00,01,02}, vector1={10,11,12}, vector2={20,21,22}.
- Same frame -> exactly 12 valid pulses, at cols 2..7 of rows 2 and 3. frame_done_o pulses with the last one, whose window is vector0={15,16,17}, vector2={35,36,37}.
- Same frame with random px_valid_i gaps -> identical 12-window sequence. matrix_o holds across gaps, valid never asserts in a gap cycle.
- Second frame fed back-to-back without frame_start_i -> counters wrapped and windows correct. Pixels of row 0/1 of the new frame produce no valid.
- frame_start_i mid-row 2 -> counters reset to (1,0) after that pixel. No valid until new row 2, col 2.
- rst_i asserted asynchronously mid-row 3 -> matrix_o=0, valid=0, frame_done_o=0 within the same cycle. After release, a new frame gives the first scenario's results.

Source files
------------

// File: rtl/sobel_window_gen.sv
// Raster-stream to 3x3 window generator: two line buffers feed a registered
// shift window whose valid strobe marks windows lying fully inside the frame.
module sobel_window_gen #(
  parameter int PIXEL_WIDTH_IN = 8,
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_HEIGHT     = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PIXEL_WIDTH_IN-1:0]   px_i,
  input  logic                        px_valid_i,
  input  logic                        frame_start_i,
  output logic [9*PIXEL_WIDTH_IN-1:0] matrix_o,
  output logic                        matrix_valid_o,
  output logic                        frame_done_o
);

  localparam int PW = PIXEL_WIDTH_IN;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [PW-1:0] lb0_q [IMG_WIDTH];
  logic [PW-1:0] lb1_q [IMG_WIDTH];
  logic [PW-1:0] lb0_rd, lb1_rd;
  logic [PW-1:0] win_q [9];
  logic [PW-1:0] win_d [9];
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  always_comb begin
    // frame_start overrides the counters for this pixel only
    cur_col = frame_start_i ? '0 : col_q;
    cur_row = frame_start_i ? '0 : row_q;
    lb0_rd  = lb0_q[cur_col];
    lb1_rd  = lb1_q[cur_col];
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (px_valid_i) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = px_i;
      valid_d  = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
      done_d   = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers are plain RAM: no reset, contents don't-care until written
  always_ff @(posedge clk_i) begin
    if (px_valid_i) begin
      lb1_q[cur_col] <= lb0_rd;
      lb0_q[cur_col] <= px_i;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_flat
    assign matrix_o[PW*k +: PW] = win_q[k];
  end

  assign matrix_valid_o = valid_q;
  assign frame_done_o   = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x4 frame with px = row*16 + col.
module tb_sobel_window_gen;

  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam logic [71:0] FIRST_WIN = 72'h222120_121110_020100;
  localparam logic [71:0] LAST_WIN  = 72'h373635_272625_171615;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [PW-1:0] px_i = '0;
  logic          px_valid_i = 1'b0;
  logic          frame_start_i = 1'b0;
  logic [9*PW-1:0] matrix_o;
  logic          matrix_valid_o;
  logic          frame_done_o;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  bit have_win = 1'b0;
  logic [71:0] last_win = '0;

  sobel_window_gen #(
    .PIXEL_WIDTH_IN (PW),
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .px_i           (px_i),
    .px_valid_i     (px_valid_i),
    .frame_start_i  (frame_start_i),
    .matrix_o       (matrix_o),
    .matrix_valid_o (matrix_valid_o),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Window whose bottom-right pixel is (c,r): vector v = row r-2+v, pix p = col c-2+p
  function automatic logic [71:0] exp_win(input int c, input int r);
    logic [71:0] w;
    w = '0;
    for (int v = 0; v < 3; v++)
      for (int p = 0; p < 3; p++)
        w[8*(3*v+p) +: 8] = 8'((r - 2 + v) * 16 + (c - 2 + p));
    return w;
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    px_valid_i    = 1'b0;
    frame_start_i = 1'b0;
    px_i          = 8'hEE;
    @(posedge clk);
    #1;
    check_eq("gap_valid", 72'(matrix_valid_o), 72'd0);
    check_eq("gap_done", 72'(frame_done_o), 72'd0);
    if (have_win) check_eq("gap_hold", matrix_o, last_win);
  endtask

  task automatic run_pixels(input int first, input int last, input bit fs, input bit gaps);
    int c;
    int r;
    bit ev;
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++) idle_cycle();
      end
      c = i % W;
      r = i / W;
      @(negedge clk);
      px_i          = 8'(r * 16 + c);
      px_valid_i    = 1'b1;
      frame_start_i = fs && (i == first);
      @(posedge clk);
      #1;
      ev = (c >= 2) && (r >= 2);
      check_eq($sformatf("valid@%0d,%0d", c, r), 72'(matrix_valid_o), 72'(ev));
      check_eq($sformatf("done@%0d,%0d", c, r), 72'(frame_done_o), 72'(c == W-1 && r == H-1));
      have_win = ev;
      if (ev) begin
        last_win = exp_win(c, r);
        check_eq($sformatf("win@%0d,%0d", c, r), matrix_o, last_win);
      end
      if (matrix_valid_o === 1'b1) nvalid++;
      if (i == 2*W + 2) check_eq("first_win", matrix_o, FIRST_WIN);
      if (i == W*H - 1) check_eq("last_win", matrix_o, LAST_WIN);
    end
    @(negedge clk);
    px_valid_i    = 1'b0;
    frame_start_i = 1'b0;
  endtask

  task automatic full_frame(input string tag, input bit fs, input bit gaps);
    nvalid = 0;
    run_pixels(0, W*H - 1, fs, gaps);
    check_eq({tag, "_nvalid"}, 72'(nvalid), 72'((W-2)*(H-2)));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_matrix", matrix_o, 72'd0);
    check_eq("rst_valid", 72'(matrix_valid_o), 72'd0);
    check_eq("rst_done", 72'(frame_done_o), 72'd0);
    @(negedge clk);
    rst_i = 1'b0;

    full_frame("frame1", 1'b1, 1'b0);
    idle_cycle();
    full_frame("gaps", 1'b1, 1'b1);
    full_frame("b2b", 1'b0, 1'b0);

    // frame_start in the middle of row 2
    nvalid = 0;
    run_pixels(0, 2*W + 3, 1'b1, 1'b0);
    check_eq("pre_fs_nvalid", 72'(nvalid), 72'd2);
    full_frame("resync", 1'b1, 1'b0);

    // asynchronous reset partway through row 3
    run_pixels(0, 3*W + 4, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_matrix", matrix_o, 72'd0);
    check_eq("arst_valid", 72'(matrix_valid_o), 72'd0);
    check_eq("arst_done", 72'(frame_done_o), 72'd0);
    @(negedge clk);
    rst_i = 1'b0;
    have_win = 1'b0;
    full_frame("post_rst", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
